// File: rtl/binary_erosion_3x3.sv
// binary_erosion_3x3: 3x3 morphological erosion on a 0x00/0xFF frame.
// Two 1-bit line buffers feed a 3-column window; a small FSM emits a flush row.
module binary_erosion_3x3 #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int FLUSH_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_gray
);

  localparam int CW = $clog2(IMG_H_DISP + 1);
  localparam int RW = $clog2(IMG_V_DISP + 1);
  localparam int FW = $clog2(IMG_H_DISP + FLUSH_GAP + 1);
  localparam int AW = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_H_DISP - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_V_DISP - 1);
  localparam logic [FW-1:0] GAP_LAST   = FW'(FLUSH_GAP - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_H_DISP - 1);
  localparam logic [FW-1:0] TAIL_LAST  = FW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_FLUSH,
    S_TAIL
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fsm_cnt_q, fsm_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          vs_prev_q, href_prev_q;
  logic          rise_d1_q, rise_d2_q;
  logic          pend_q, pend_d;
  logic          relaunch_q, relaunch_d;
  logic [2:0]    cv0_q, cv1_q, cv2_q, cv0_d;
  logic          v1_q, v2_q, int1_q, int2_q;
  logic          v1_d, int1_d;
  logic          post_vsync_q, post_vsync_d;
  logic          post_href_q, post_href_d;
  logic [7:0]    post_gray_q, post_gray_d;

  logic          lb_a_q [IMG_H_DISP];
  logic          lb_b_q [IMG_H_DISP];

  logic          vs_rise, act, href_fall, in_bit;
  logic          rd_a, rd_b, win_and;
  logic [AW-1:0] lb_idx;

  assign vs_rise   = per_img_vsync & ~vs_prev_q;
  assign act       = per_img_href & (state_q != S_IDLE);
  assign href_fall = href_prev_q & ~per_img_href & (state_q != S_IDLE);
  assign in_bit    = per_img_gray[7];
  assign lb_idx    = col_cnt_q[AW-1:0];
  assign rd_a      = lb_a_q[lb_idx];
  assign rd_b      = lb_b_q[lb_idx];
  assign win_and   = &{cv0_q, cv1_q, cv2_q};

  // Line/row counters and the first window stage (column vector + qualifiers)
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (href_fall)
      col_cnt_d = '0;
    else if (act)
      col_cnt_d = col_cnt_q + 1'b1;
    if (vs_rise)
      row_cnt_d = '0;
    else if (href_fall)
      row_cnt_d = row_cnt_q + 1'b1;
    cv0_d  = {rd_b, rd_a, in_bit};
    v1_d   = act & (row_cnt_q != '0);
    int1_d = act & (row_cnt_q >= RW'(2))
           & (col_cnt_q != '0) & (col_cnt_q != COL_LAST);
  end

  // Frame sequencing, flush row and output selection
  always_comb begin
    state_d      = state_q;
    fsm_cnt_d    = fsm_cnt_q;
    pend_d       = pend_q;
    relaunch_d   = 1'b0;
    post_vsync_d = post_vsync_q;
    post_href_d  = v2_q;
    post_gray_d  = (v2_q & int2_q & win_and) ? 8'hFF : 8'h00;
    if (vs_rise && (state_q == S_GAP || state_q == S_FLUSH ||
                    state_q == S_TAIL))
      pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        post_vsync_d = 1'b0;
        if (vs_rise)
          state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (rise_d2_q || relaunch_q)
          post_vsync_d = 1'b1;
        if (href_fall && row_cnt_q == ROW_LAST) begin
          state_d   = S_GAP;
          fsm_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (fsm_cnt_q == GAP_LAST) begin
          state_d   = S_FLUSH;
          fsm_cnt_d = '0;
        end else begin
          fsm_cnt_d = fsm_cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        post_href_d = 1'b1;
        post_gray_d = 8'h00;
        if (fsm_cnt_q == FLUSH_LAST) begin
          state_d   = S_TAIL;
          fsm_cnt_d = '0;
        end else begin
          fsm_cnt_d = fsm_cnt_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (fsm_cnt_q == TAIL_LAST) begin
          post_vsync_d = 1'b0;
          fsm_cnt_d    = '0;
          if (pend_q || vs_rise) begin
            state_d    = S_ACTIVE;
            relaunch_d = 1'b1;
            pend_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          fsm_cnt_d = fsm_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, window pipeline and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fsm_cnt_q    <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      vs_prev_q    <= 1'b1;
      href_prev_q  <= 1'b0;
      rise_d1_q    <= 1'b0;
      rise_d2_q    <= 1'b0;
      pend_q       <= 1'b0;
      relaunch_q   <= 1'b0;
      cv0_q        <= '0;
      cv1_q        <= '0;
      cv2_q        <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      int1_q       <= 1'b0;
      int2_q       <= 1'b0;
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_gray_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      fsm_cnt_q    <= fsm_cnt_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      vs_prev_q    <= per_img_vsync;
      href_prev_q  <= per_img_href;
      rise_d1_q    <= vs_rise;
      rise_d2_q    <= rise_d1_q;
      pend_q       <= pend_d;
      relaunch_q   <= relaunch_d;
      cv0_q        <= cv0_d;
      cv1_q        <= cv0_q;
      cv2_q        <= cv1_q;
      v1_q         <= v1_d;
      v2_q         <= v1_q;
      int1_q       <= int1_d;
      int2_q       <= int1_q;
      post_vsync_q <= post_vsync_d;
      post_href_q  <= post_href_d;
      post_gray_q  <= post_gray_d;
    end
  end

  // Line buffers: lb_a holds the previous row, lb_b the row before it
  always_ff @(posedge clk) begin
    if (act) begin
      lb_a_q[lb_idx] <= in_bit;
      lb_b_q[lb_idx] <= rd_a;
    end
  end

  assign post_img_vsync = post_vsync_q;
  assign post_img_href  = post_href_q;
  assign post_img_gray  = post_gray_q;

endmodule

// File: tb/tb_binary_erosion_3x3.sv
// tb_binary_erosion_3x3: directed + random frames on a 16x8 instance,
// checked against a plain-array erosion reference.
module tb_binary_erosion_3x3;

  localparam int W  = 16;
  localparam int V  = 8;
  localparam int G  = 4;
  localparam int HB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic       hr = 1'b0;
  logic [7:0] gi = 8'h00;
  logic       post_vsync, post_href;
  logic [7:0] post_gray;

  binary_erosion_3x3 #(
    .IMG_H_DISP(W),
    .IMG_V_DISP(V),
    .FLUSH_GAP (G)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .per_img_vsync (vs),
    .per_img_href  (hr),
    .per_img_gray  (gi),
    .post_img_vsync(post_vsync),
    .post_img_href (post_href),
    .post_img_gray (post_gray)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  bit         img [V][W];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         len_q[$];
  int         hrise_q[$];
  int         vrise_q[$];
  int         gz_viol = 0;
  int         run = 0;
  logic       ph_prev = 1'b0;
  logic       pv_prev = 1'b0;
  int         vs_drv, row1_drv;

  always @(negedge clk) begin
    if (post_href === 1'b1) begin
      cap_q.push_back(post_gray);
      run = run + 1;
    end else begin
      if (post_gray !== 8'h00) gz_viol = gz_viol + 1;
      if (ph_prev === 1'b1) len_q.push_back(run);
      run = 0;
    end
    if (post_href === 1'b1 && ph_prev !== 1'b1) hrise_q.push_back(cyc);
    if (post_vsync === 1'b1 && pv_prev !== 1'b1) vrise_q.push_back(cyc);
    ph_prev = post_href;
    pv_prev = post_vsync;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_caps();
    exp_q.delete();
    cap_q.delete();
    len_q.delete();
    hrise_q.delete();
    vrise_q.delete();
    gz_viol = 0;
  endtask

  task automatic fill_const(input bit b);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = b;
  endtask

  task automatic fill_rand(input int pct_fg);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ($urandom_range(99, 0) < pct_fg);
  endtask

  // Reference: output is foreground only if all 9 neighbours are, never on the border
  task automatic build_exp();
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < W; c++) begin
        bit e;
        e = 1'b0;
        if (r >= 1 && r <= V - 2 && c >= 1 && c <= W - 2) begin
          e = 1'b1;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              e = e & img[r + dr][c + dc];
        end
        exp_q.push_back(e ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic drive_frame(input int vs_low, input bit rand_gray,
                             input int rst_row, input int rst_col);
    @(posedge clk); #1;
    vs = 1'b1;
    vs_drv = cyc;
    repeat (3) @(posedge clk);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < W; c++) begin
        @(posedge clk); #1;
        hr = 1'b1;
        if (rand_gray)
          gi = {img[r][c], 7'($urandom)};
        else
          gi = img[r][c] ? 8'hFF : 8'h00;
        if (r == 1 && c == 0) row1_drv = cyc;
        if (r == rst_row && c == rst_col + 1) rst = 1'b0;
        if (r == rst_row && c == rst_col) begin
          #2 rst = 1'b1;
          #1;
          check("rst_mid_vsync", post_vsync, 0);
          check("rst_mid_href", post_href, 0);
          check("rst_mid_gray", post_gray, 0);
          clear_caps();
        end
      end
      @(posedge clk); #1;
      hr = 1'b0;
      gi = 8'h00;
      if (r != V - 1) repeat (HB - 1) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1 vs = 1'b0;
    repeat (vs_low) @(posedge clk);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (post_vsync === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_in_time"}, (k < 400), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag, input int nframes);
    int n, mism, first;
    check({tag, "_px_count"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    mism = 0;
    first = -1;
    for (int i = 0; i < n; i++)
      if (cap_q[i] !== exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    check($sformatf("%s_px_mism_first%0d", tag, first), mism, 0);
    check({tag, "_lines"}, len_q.size(), V * nframes);
    foreach (len_q[i])
      check($sformatf("%s_len%0d", tag, i), len_q[i], W);
    check({tag, "_vs_pulses"}, vrise_q.size(), nframes);
    check({tag, "_gray_idle0"}, gz_viol, 0);
  endtask

  task automatic check_latency(input string tag);
    check({tag, "_href_lat"},
          (hrise_q.size() > 0) ? hrise_q[0] : -1, row1_drv + 3);
    check({tag, "_vs_lat"},
          (vrise_q.size() > 0) ? vrise_q[0] : -1, vs_drv + 3);
  endtask

  initial begin
    int nff, idx;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vsync", post_vsync, 0);
    check("reset_href", post_href, 0);
    check("reset_gray", post_gray, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    clear_caps();

    fill_const(1'b1);
    build_exp();
    drive_frame(5, 1'b0, -1, -1);
    wait_done("allff");
    check_latency("allff");
    compare("allff", 1);
    clear_caps();

    fill_const(1'b1);
    img[3][7] = 1'b0;
    build_exp();
    drive_frame(5, 1'b0, -1, -1);
    wait_done("hole");
    compare("hole", 1);
    clear_caps();

    fill_const(1'b0);
    for (int r = 3; r <= 5; r++)
      for (int c = 6; c <= 8; c++)
        img[r][c] = 1'b1;
    build_exp();
    drive_frame(5, 1'b0, -1, -1);
    wait_done("blk");
    nff = 0;
    idx = -1;
    foreach (cap_q[i])
      if (cap_q[i] === 8'hFF) begin
        nff++;
        idx = i;
      end
    check("blk_ff_count", nff, 1);
    check("blk_ff_index", idx, 4 * W + 7);
    compare("blk", 1);
    clear_caps();

    fill_rand(90);
    build_exp();
    drive_frame(2, 1'b0, -1, -1);
    fill_rand(85);
    build_exp();
    drive_frame(5, 1'b1, -1, -1);
    wait_done("b2b");
    compare("b2b", 2);
    clear_caps();

    fill_rand(90);
    drive_frame(5, 1'b0, 4, 5);
    wait_done("rstpart");
    check("rstpart_no_px", cap_q.size(), 0);
    check("rstpart_no_vs", vrise_q.size(), 0);
    clear_caps();

    fill_rand(88);
    build_exp();
    drive_frame(5, 1'b1, -1, -1);
    wait_done("postrst");
    check_latency("postrst");
    compare("postrst", 1);
    clear_caps();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
